// File: rtl/keycode_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : keycode_event_decoder
// Description : Debounces five USB HID key slots. Each accepted snapshot is
//               compared against the previously committed one, and the
//               resulting press/release events go into a show-ahead FIFO.
//               The decoder also keeps held flags for WASD, arrows and space.
// Revision    : 1.0 - initial release
// ============================================================================
module keycode_event_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [7:0] keycode_in0,
    input  logic [7:0] keycode_in1,
    input  logic [7:0] keycode_in2,
    input  logic [7:0] keycode_in3,
    input  logic [7:0] keycode_in4,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_press,
    output logic [8:0] held,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int             c_AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_AW:0]  c_DEPTH  = FIFO_DEPTH[c_AW:0];
    localparam logic [7:0]     c_STABLE = STABLE_CYCLES[7:0];
    localparam logic [7:0]     c_ROLLOVER = 8'h01;
    localparam logic [2:0]     c_LAST_SLOT = 3'd4;

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_SCAN_PRESS = 2'd1;
    localparam logic [1:0] c_SCAN_REL   = 2'd2;
    localparam logic [1:0] c_COMMIT     = 2'd3;

    // Slot 0 sits in the low byte so that w_keys[i] is keycode_in<i>
    logic [4:0][7:0] w_keys;
    assign w_keys = {keycode_in4, keycode_in3, keycode_in2, keycode_in1, keycode_in0};

    logic [4:0][7:0] r_keys_q;
    logic [7:0]      r_stable_cnt;
    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [4:0][7:0] r_snap;
    logic [4:0][7:0] r_prev;
    logic [2:0]      r_idx;
    logic [8:0]      r_held;
    logic            r_overflow;

    logic            w_rollover;
    logic            w_capture;
    logic            w_scan;
    logic            w_commit;
    logic [4:0][7:0] w_cur;
    logic [4:0][7:0] w_oth;
    logic [7:0]      w_code;
    logic            w_in_other;
    logic            w_dup;
    logic            w_push;
    logic            w_push_press;

    logic [8:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_wr_en;
    logic            w_drop;
    logic [8:0]      w_head;

    // Maps a snapshot to the held flags, one bit per tracked key code
    function automatic logic [8:0] f_held(input logic [4:0][7:0] keys);
        logic [8:0] m;
        m = '0;
        for (int k = 0; k < 5; k++) begin
            case (keys[k])
                8'h1A:   m[0] = 1'b1;
                8'h04:   m[1] = 1'b1;
                8'h16:   m[2] = 1'b1;
                8'h07:   m[3] = 1'b1;
                8'h52:   m[4] = 1'b1;
                8'h51:   m[5] = 1'b1;
                8'h50:   m[6] = 1'b1;
                8'h4F:   m[7] = 1'b1;
                8'h2C:   m[8] = 1'b1;
                default: ;
            endcase
        end
        return m;
    endfunction

    // A snapshot that reports keyboard rollover is never accepted
    always_comb begin
        w_rollover = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (r_keys_q[k] == c_ROLLOVER) w_rollover = 1'b1;
        end
    end

    // Input sampler and stability counter; COMMIT restarts the count
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_keys_q     <= '0;
            r_stable_cnt <= '0;
        end else begin
            r_keys_q <= w_keys;
            if (w_commit || (w_keys != r_keys_q)) begin
                r_stable_cnt <= '0;
            end else if (r_stable_cnt != 8'hFF) begin
                r_stable_cnt <= r_stable_cnt + 8'd1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_scan      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if ((r_stable_cnt >= c_STABLE) && (r_keys_q != r_prev) && !w_rollover) begin
                    w_capture   = 1'b1;
                    w_state_nxt = c_SCAN_PRESS;
                end
            end
            c_SCAN_PRESS: begin
                w_scan = 1'b1;
                if (r_idx == c_LAST_SLOT) w_state_nxt = c_SCAN_REL;
            end
            c_SCAN_REL: begin
                w_scan = 1'b1;
                if (r_idx == c_LAST_SLOT) w_state_nxt = c_COMMIT;
            end
            c_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Slot examiner: the release pass is the press pass with snap/prev swapped
    always_comb begin
        w_cur      = (r_state == c_SCAN_REL) ? r_prev : r_snap;
        w_oth      = (r_state == c_SCAN_REL) ? r_snap : r_prev;
        w_code     = w_cur[r_idx];
        w_in_other = 1'b0;
        w_dup      = 1'b0;
        for (int j = 0; j < 5; j++) begin
            if (w_oth[j] == w_code) w_in_other = 1'b1;
            if ((3'(j) < r_idx) && (w_cur[j] == w_code)) w_dup = 1'b1;
        end
        w_push       = w_scan && (w_code != 8'h00) && !w_in_other && !w_dup;
        w_push_press = (r_state == c_SCAN_PRESS);
    end

    // Snapshot, slot index, committed snapshot and held flags
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_snap <= '0;
            r_prev <= '0;
            r_idx  <= '0;
            r_held <= '0;
        end else begin
            if (w_capture) begin
                r_snap <= r_keys_q;
                r_idx  <= '0;
            end else if (w_scan) begin
                r_idx <= (r_idx == c_LAST_SLOT) ? 3'd0 : r_idx + 3'd1;
            end
            if (w_commit) begin
                r_prev <= r_snap;
                r_held <= f_held(r_snap);
            end
        end
    end

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && evt_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    // Event storage; contents are only observed while non-empty
    always_ff @(posedge clk_clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= {w_push_press, w_code};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag; a new drop wins over a simultaneous clear
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign evt_valid = !w_empty;
    assign evt_code  = w_empty ? 8'h00 : w_head[7:0];
    assign evt_press = !w_empty && w_head[8];
    assign held      = r_held;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
